vga_sprite_compositor: RTL

Parametrised, pipelined pixel compositor for the VGA path. It merges up to NUM_SPRITES keyed sprite layers, one overlay layer (health and shield bars, game-over art) and a background colour into one registered 12-bit RGB stream. It sits between the VGA sync generator and the pins. It replaces hard-wired two-player drawing with per-sprite enable, horizontal flip, frame-latched positions, configurable transparency key and frame-timed flash tinting.

---
 rtl/vga_sprite_compositor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor: 3-stage compositor of keyed sprites, overlay and background into a registered 12-bit RGB stream.
// Sprite positions/enables/flips are latched at frame start; per-sprite flash timers count down once per frame.
module vga_sprite_compositor #(
    parameter int          NUM_SPRITES  = 2,
    parameter int          SPR_W_LOG2   = 7,
    parameter int          SPR_H_LOG2   = 7,
    parameter logic [11:0] TKEY         = 12'h00C,
    parameter logic [11:0] TKEY_MASK    = 12'hFFC,
    parameter int          FLASH_FRAMES = 8,
    parameter int          FLASH_BLINK  = 0,
    parameter logic [11:0] FLASH_COLOR  = 12'hF00,
    parameter logic [11:0] SHIELD_COLOR = 12'hF0F
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [9:0]                                     hCount,
    input  logic [9:0]                                     vCount,
    input  logic                                           bright,
    input  logic [11:0]                                    bg_rgb,
    input  logic                                           ovl_valid,
    input  logic [11:0]                                    ovl_rgb,
    input  logic [10*NUM_SPRITES-1:0]                      spr_x,
    input  logic [10*NUM_SPRITES-1:0]                      spr_y,
    input  logic [NUM_SPRITES-1:0]                         spr_en,
    input  logic [NUM_SPRITES-1:0]                         spr_flip,
    input  logic [NUM_SPRITES-1:0]                         spr_shield,
    input  logic [NUM_SPRITES-1:0]                         flash_req,
    output logic [(SPR_W_LOG2+SPR_H_LOG2)*NUM_SPRITES-1:0] spr_addr,
    input  logic [12*NUM_SPRITES-1:0]                      spr_pixel,
    output logic [11:0]                                    rgb,
    output logic                                           bright_out
);
    localparam int N = NUM_SPRITES;
    localparam int AW = SPR_W_LOG2 + SPR_H_LOG2;
    localparam logic [10:0] SW = 11'(1 << SPR_W_LOG2);
    localparam logic [10:0] SH = 11'(1 << SPR_H_LOG2);

    logic                 fs;
    logic [10*N-1:0]      sx_q, sx_d, sy_q, sy_d;
    logic [N-1:0]         sen_q, sen_d, sflip_q, sflip_d;
    logic [N-1:0][3:0]    tmr_q, tmr_d;
    logic [AW*N-1:0]      addr_q, addr_d;
    logic [N-1:0]         hit_d, flash_d, opq;
    logic [N-1:0]         hit1_q, shield1_q, flash1_q, hit2_q, shield2_q, flash2_q;
    logic                 bright1_q, bright2_q, ovl1_q, ovl2_q, bright_out_q;
    logic [11:0]          ovl_rgb1_q, ovl_rgb2_q, bg1_q, bg2_q, rgb_q, rgb_d;
    logic [N-1:0][11:0]   col;

    // Shadows are bypassed on the frame-start pixel so the new state applies to (0,0) itself.
    assign fs      = hCount == 10'd0 && vCount == 10'd0;
    assign sx_d    = fs ? spr_x : sx_q;
    assign sy_d    = fs ? spr_y : sy_q;
    assign sen_d   = fs ? spr_en : sen_q;
    assign sflip_d = fs ? spr_flip : sflip_q;

    for (genvar i = 0; i < N; i++) begin : g_spr
        logic [9:0]  x, y;
        logic [11:0] pix;
        assign x = sx_d[10*i +: 10];
        assign y = sy_d[10*i +: 10];
        // 11-bit compares keep sprites overhanging column/row 1023 from wrapping to 0.
        assign hit_d[i] = sen_d[i]
                          && {1'b0, hCount} >= {1'b0, x} && {1'b0, hCount} < {1'b0, x} + SW
                          && {1'b0, vCount} >= {1'b0, y} && {1'b0, vCount} < {1'b0, y} + SH;
        assign addr_d[AW*i +: AW] = hit_d[i] ? {SPR_H_LOG2'(vCount - y),
                                                SPR_W_LOG2'(hCount - x) ^ {SPR_W_LOG2{sflip_d[i]}}} : '0;
        assign flash_d[i] = tmr_q[i] != 4'd0 && (FLASH_BLINK == 0 || tmr_q[i][1]);
        assign tmr_d[i] = flash_req[i] ? 4'(FLASH_FRAMES)
                        : (fs && tmr_q[i] != 4'd0) ? tmr_q[i] - 4'd1 : tmr_q[i];
        assign pix    = spr_pixel[12*i +: 12];
        assign opq[i] = hit2_q[i] && (pix & TKEY_MASK) != (TKEY & TKEY_MASK);
        assign col[i] = shield2_q[i] ? SHIELD_COLOR : flash2_q[i] ? FLASH_COLOR : pix;
    end

    always_comb begin
        rgb_d = bg2_q;
        for (int k = N - 1; k >= 0; k--) rgb_d = opq[k] ? col[k] : rgb_d;
        rgb_d = !bright2_q ? 12'd0 : ovl2_q ? ovl_rgb2_q : rgb_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q         <= '0;
            sy_q         <= '0;
            sen_q        <= '0;
            sflip_q      <= '0;
            tmr_q        <= '0;
            addr_q       <= '0;
            hit1_q       <= '0;
            shield1_q    <= '0;
            flash1_q     <= '0;
            bright1_q    <= 1'b0;
            ovl1_q       <= 1'b0;
            ovl_rgb1_q   <= '0;
            bg1_q        <= '0;
            hit2_q       <= '0;
            shield2_q    <= '0;
            flash2_q     <= '0;
            bright2_q    <= 1'b0;
            ovl2_q       <= 1'b0;
            ovl_rgb2_q   <= '0;
            bg2_q        <= '0;
            rgb_q        <= '0;
            bright_out_q <= 1'b0;
        end else begin
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            sen_q        <= sen_d;
            sflip_q      <= sflip_d;
            tmr_q        <= tmr_d;
            addr_q       <= addr_d;
            hit1_q       <= hit_d;
            shield1_q    <= spr_shield;
            flash1_q     <= flash_d;
            bright1_q    <= bright;
            ovl1_q       <= ovl_valid;
            ovl_rgb1_q   <= ovl_rgb;
            bg1_q        <= bg_rgb;
            hit2_q       <= hit1_q;
            shield2_q    <= shield1_q;
            flash2_q     <= flash1_q;
            bright2_q    <= bright1_q;
            ovl2_q       <= ovl1_q;
            ovl_rgb2_q   <= ovl_rgb1_q;
            bg2_q        <= bg1_q;
            rgb_q        <= rgb_d;
            bright_out_q <= bright2_q;
        end
    end

    assign spr_addr   = addr_q;
    assign rgb        = rgb_q;
    assign bright_out = bright_out_q;
endmodule
